// File: rtl/wddl_pkg.sv
// Shared types for the WDDL dual-rail decoder: rail codes, FSM states, error codes.
package wddl_pkg;

  localparam int unsigned TIMEOUT_CYC_DEF = 16;
  localparam int unsigned CNT_W           = 8;

  // Packed {t,f} rail pair encoding
  typedef enum logic [1:0] {
    SPACER   = 2'b00,
    ZERO     = 2'b01,
    ONE      = 2'b10,
    CONFLICT = 2'b11
  } rail_e;

  typedef enum logic [1:0] {
    ST_PRE     = 2'd0,
    ST_EVAL    = 2'd1,
    ST_OUT     = 2'd2,
    ST_RECOVER = 2'd3
  } dec_state_e;

  typedef enum logic [1:0] {
    ERR_CONFLICT   = 2'd0,
    ERR_TIMEOUT    = 2'd1,
    ERR_EARLY_PRCH = 2'd2,
    ERR_OVERRUN    = 2'd3
  } err_code_e;

  function automatic rail_e classify_bit(input logic t, input logic f);
    return rail_e'({t, f});
  endfunction

endpackage

// File: rtl/wddl_rail_classify.sv
// Combinational word-level flags over a dual-rail word: all spacer, complete, conflict.
module wddl_rail_classify
  import wddl_pkg::*;
#(
  parameter int unsigned WIDTH = 128
) (
  input  logic [WIDTH-1:0] t_i,
  input  logic [WIDTH-1:0] f_i,
  output logic             all_spacer_c_o,
  output logic             complete_c_o,
  output logic             conflict_c_o
);

  always_comb begin
    all_spacer_c_o = 1'b1;
    complete_c_o   = 1'b1;
    conflict_c_o   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      case (classify_bit(t_i[i], f_i[i]))
        SPACER: complete_c_o = 1'b0;
        CONFLICT: begin
          conflict_c_o   = 1'b1;
          complete_c_o   = 1'b0;
          all_spacer_c_o = 1'b0;
        end
        default: all_spacer_c_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/wddl_dualrail_decoder.sv
// WDDL dual-rail to single-ended decoder with wave tracking and protocol error reporting.
// Define WDDL_DEC_ERRCNT_EN to add the saturating err_count output.
module wddl_dualrail_decoder
  import wddl_pkg::*;
#(
  parameter int unsigned WIDTH       = 128,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`ifdef WDDL_DEC_ERRCNT_EN
  ,
  parameter int unsigned ERRCNT_W    = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prch,
  input  logic [WIDTH-1:0] dr_t,
  input  logic [WIDTH-1:0] dr_f,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_valid,
  output logic [1:0]       err_code
`ifdef WDDL_DEC_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_count
`endif
);

  logic             r_prch_q, r_prch_prev_q;
  logic [WIDTH-1:0] r_t_q, r_f_q;
  dec_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             err_valid_q, err_valid_d;
  err_code_e        err_code_q, err_code_d;
  logic             err_hit;
  err_code_e        err_sel;
  logic             all_spacer, complete, conflict;
`ifdef WDDL_DEC_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
`endif

  wddl_rail_classify #(.WIDTH(WIDTH)) u_classify (
    .t_i            (r_t_q),
    .f_i            (r_f_q),
    .all_spacer_c_o (all_spacer),
    .complete_c_o   (complete),
    .conflict_c_o   (conflict)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prch_q      <= 1'b0;
      r_prch_prev_q <= 1'b0;
      r_t_q         <= '0;
      r_f_q         <= '0;
      state_q       <= ST_RECOVER;
      cnt_q         <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      err_valid_q   <= 1'b0;
      err_code_q    <= ERR_CONFLICT;
`ifdef WDDL_DEC_ERRCNT_EN
      err_cnt_q     <= '0;
`endif
    end else begin
      r_prch_q      <= prch;
      r_prch_prev_q <= r_prch_q;
      r_t_q         <= dr_t;
      r_f_q         <= dr_f;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      err_valid_q   <= err_valid_d;
      err_code_q    <= err_code_d;
`ifdef WDDL_DEC_ERRCNT_EN
      err_cnt_q     <= err_cnt_d;
`endif
    end
  end

  // Wave tracking; at most one error per cycle, earlier checks win
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_hit     = 1'b0;
    err_sel     = ERR_CONFLICT;

    case (state_q)
      ST_RECOVER: begin
        if (r_prch_q && all_spacer) state_d = ST_PRE;
      end
      ST_PRE: begin
        if (!r_prch_q) begin
          state_d = ST_EVAL;
          cnt_d   = '0;
        end else if (conflict) begin
          err_hit = 1'b1;
          err_sel = ERR_CONFLICT;
          state_d = ST_RECOVER;
        end
      end
      ST_EVAL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (conflict) begin
          err_hit = 1'b1;
          err_sel = ERR_CONFLICT;
          state_d = ST_RECOVER;
        end else if (complete) begin
          out_data_d  = r_t_q;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else if (r_prch_q) begin
          err_hit = 1'b1;
          err_sel = ERR_EARLY_PRCH;
          state_d = ST_RECOVER;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_hit = 1'b1;
          err_sel = ERR_TIMEOUT;
          state_d = ST_RECOVER;
        end
      end
      ST_OUT: begin
        // A new evaluate wave while holding a word: the new word is dropped
        if (!r_prch_q && r_prch_prev_q) begin
          err_hit = 1'b1;
          err_sel = ERR_OVERRUN;
        end
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = r_prch_q ? ST_PRE : ST_RECOVER;
        end
      end
      default: state_d = ST_RECOVER;
    endcase

    err_valid_d = err_hit;
    err_code_d  = err_hit ? err_sel : err_code_q;
  end

`ifdef WDDL_DEC_ERRCNT_EN
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_hit && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
  end

  assign err_count = err_cnt_q;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_wddl_dualrail_decoder.sv
// Directed bench for wddl_dualrail_decoder (WIDTH=8, TIMEOUT_CYC=4, ERRCNT_W=2 when enabled).
module tb_wddl_dualrail_decoder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         prch;
  logic [W-1:0] dr_t, dr_f;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         err_valid;
  logic [1:0]   err_code;
`ifdef WDDL_DEC_ERRCNT_EN
  logic [1:0]   err_count;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  wddl_dualrail_decoder #(
    .WIDTH       (W),
    .TIMEOUT_CYC (4)
`ifdef WDDL_DEC_ERRCNT_EN
    ,
    .ERRCNT_W    (2)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prch      (prch),
    .dr_t      (dr_t),
    .dr_f      (dr_f),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_valid (err_valid),
    .err_code  (err_code)
`ifdef WDDL_DEC_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic p, input logic [W-1:0] t, input logic [W-1:0] f);
    prch = p;
    dr_t = t;
    dr_f = f;
  endtask

  // Precharge with spacers long enough to reach PRE from RECOVER
  task automatic to_pre();
    drive(1'b1, '0, '0);
    step();
    step();
  endtask

  // From PRE: one spacer evaluate cycle, then the word; returns with the word registered in EVAL
  task automatic eval_word(input logic [W-1:0] t, input logic [W-1:0] f);
    drive(1'b0, '0, '0);
    step();
    drive(1'b0, t, f);
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, '0, '0);
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_err_valid", 32'(err_valid), 0);
    chk("rst_err_code", 32'(err_code), 0);
`ifdef WDDL_DEC_ERRCNT_EN
    chk("rst_err_count", 32'(err_count), 0);
`endif
    rst_n = 1'b1;
    to_pre();

    // Nominal decode and backpressure
    eval_word(8'hA5, 8'h5A);
    chk("nom_not_yet", 32'(out_valid), 0);
    step();
    chk("nom_valid", 32'(out_valid), 1);
    chk("nom_data", 32'(out_data), 'hA5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nom_hold_valid", 32'(out_valid), 1);
      chk("nom_hold_data", 32'(out_data), 'hA5);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("nom_accept", 32'(out_valid), 0);
    chk("nom_no_err", 32'(err_valid), 0);

    // Conflict, then RECOVER must wait for a clean spacer precharge
    to_pre();
    eval_word(8'h01, 8'h01);
    step();
    chk("cfl_err_valid", 32'(err_valid), 1);
    chk("cfl_code", 32'(err_code), 0);
    chk("cfl_no_out", 32'(out_valid), 0);
    step();
    chk("cfl_strobe_once", 32'(err_valid), 0);
    drive(1'b1, 8'h01, 8'h00);
    step();
    step();
    step();
    eval_word(8'h11, 8'hEE);
    step();
    step();
    chk("cfl_stay_recover", 32'(out_valid), 0);
    chk("cfl_recover_quiet", 32'(err_valid), 0);

    // Timeout on the fourth EVAL cycle
    to_pre();
    eval_word(8'h0F, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("tmo_not_yet", 32'(err_valid), 0);
    end
    step();
    chk("tmo_err_valid", 32'(err_valid), 1);
    chk("tmo_code", 32'(err_code), 1);
    chk("tmo_no_out", 32'(out_valid), 0);
    step();
    chk("tmo_strobe_once", 32'(err_valid), 0);
    chk("tmo_code_hold", 32'(err_code), 1);

    // Early precharge with a partial word
    to_pre();
    eval_word(8'h0F, 8'h00);
    step();
    drive(1'b1, 8'h0F, 8'h00);
    step();
    chk("early_not_yet", 32'(err_valid), 0);
    step();
    chk("early_err_valid", 32'(err_valid), 1);
    chk("early_code", 32'(err_code), 2);
    chk("early_no_out", 32'(out_valid), 0);

    // Overrun: second wave while 3C is still pending
    to_pre();
    eval_word(8'h3C, 8'hC3);
    step();
    chk("ovr_valid", 32'(out_valid), 1);
    chk("ovr_data", 32'(out_data), 'h3C);
    drive(1'b1, '0, '0);
    step();
    step();
    chk("ovr_prch_quiet", 32'(err_valid), 0);
    drive(1'b0, 8'hC3, 8'h3C);
    step();
    chk("ovr_not_yet", 32'(err_valid), 0);
    step();
    chk("ovr_err_valid", 32'(err_valid), 1);
    chk("ovr_code", 32'(err_code), 3);
    chk("ovr_data_kept", 32'(out_data), 'h3C);
    chk("ovr_still_valid", 32'(out_valid), 1);
    step();
    chk("ovr_strobe_once", 32'(err_valid), 0);
    chk("ovr_data_kept2", 32'(out_data), 'h3C);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("ovr_accept", 32'(out_valid), 0);
    step();
    step();
    chk("ovr_no_second", 32'(out_valid), 0);

    // Accept and overrun in the same cycle
    to_pre();
    eval_word(8'h5A, 8'hA5);
    step();
    chk("both_valid", 32'(out_valid), 1);
    chk("both_data", 32'(out_data), 'h5A);
    drive(1'b1, '0, '0);
    step();
    step();
    drive(1'b0, 8'h0F, 8'hF0);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("both_accept", 32'(out_valid), 0);
    chk("both_err_valid", 32'(err_valid), 1);
    chk("both_code", 32'(err_code), 3);
`ifdef WDDL_DEC_ERRCNT_EN
    chk("cnt_saturated", 32'(err_count), 3);
`endif

    // Reset with a pending word drops it silently
    to_pre();
    eval_word(8'h96, 8'h69);
    step();
    chk("rstw_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rstw_valid_drop", 32'(out_valid), 0);
    chk("rstw_data_clr", 32'(out_data), 0);
    chk("rstw_no_err", 32'(err_valid), 0);
`ifdef WDDL_DEC_ERRCNT_EN
    chk("rstw_cnt_clr", 32'(err_count), 0);
`endif

    // Reset mid-EVAL, then a complete word without precharge must not decode
    to_pre();
    eval_word(8'h0F, 8'h00);
    rst_n = 1'b0;
    drive(1'b0, 8'hFF, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("rste_no_out", 32'(out_valid), 0);
    chk("rste_no_err", 32'(err_valid), 0);
    chk("rste_code_clr", 32'(err_code), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
